mem_scheduler: RTL and testbench
================================

# mem_scheduler

Shares the single line-wide memory port (cacheline adapter side) between the instruction cache, the data cache and an internal next-line instruction prefetcher. Replaces direct I/D arbitration with round-robin fairness between the two caches. Adds a one-line prefetch buffer that serves sequential instruction misses without a memory transaction. Sits between both caches' pmem ports and the cacheline adapter.

## Interface
- PREFETCH_EN, 1: 1 enables the next-line prefetcher and buffer; 0 makes the block a pure I/D round-robin arbiter.
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- inst_address  in  32  I-cache line address; bits [4:0] ignored.
- inst_read  in  1  I-cache line read request, held until inst_resp.
- inst_resp  out  1  one-cycle completion pulse to the I-cache.
- inst_rdata  out  256  line data, valid while inst_resp=1.
- data_address  in  32  D-cache line address; bits [4:0] ignored.
- data_read  in  1  D-cache line read request, held until data_resp.
- data_write  in  1  D-cache writeback request, held until data_resp; never asserted together with data_read.
- data_wdata  in  256  writeback line.
- data_resp  out  1  one-cycle completion pulse to the D-cache.
- data_rdata  out  256  line data, valid while data_resp=1.
- mem_address  out  32  line address to the adapter, {addr[31:5],5'b0}.
- mem_read  out  1  adapter read, held until mem_resp.
- mem_write  out  1  adapter write, held until mem_resp.
- mem_line_write  out  256  write line, equal to data_wdata during a write.
- mem_line_read  in  256  adapter read line, valid with mem_resp.
- mem_resp  in  1  adapter completion pulse.

## Operation
- States: IDLE, INST, DATA, PREF, HIT, DONE.
- IDLE decision, in priority order:
  1. inst_read with buf_valid and inst_address[31:5]==buf_tag: go to HIT.
  2. Both caches requesting: grant the one not granted last (last_grant).
  3. One cache requesting: grant that cache.
  4. pf_pending and no cache request: go to PREF.
- INST/DATA/PREF: drive mem_address and mem_read or mem_write until mem_resp.
  - In the mem_resp cycle: pulse inst_resp or data_resp, with rdata driven from mem_line_read. PREF pulses no response.
  - Next state is DONE.
- HIT: pulse inst_resp with inst_rdata=buf_line. Next state is DONE. No memory access.
- DONE: one cycle; all requests ignored so a held request is not served twice. Next state is IDLE.
- last_grant updates on every INST or DATA grant. HIT and PREF leave it unchanged.
- Prefetch (PREFETCH_EN=1):
  - Trigger: INST completion or HIT completion.
  - On trigger: pf_addr = ({inst_address[31:5]}+1) mod 2^27, pf_pending=1, buf_valid=0.
  - PREF completion: buf_line=mem_line_read, buf_tag=pf_addr, buf_valid=1, pf_pending=0.
  - pf_addr wraps from 0x7FFFFFF to 0.
- Coherence: on a DATA write completion:
  - If data_address[31:5]==buf_tag, clear buf_valid.
  - If data_address[31:5]==pf_addr, the line is still fetched afterwards. Memory order is preserved, so the fetch returns the new data.
- An in-flight PREF is never aborted. Cache requests wait for it to finish.
- Data writes never touch the buffer contents, only buf_valid.

## Timing
- Reset values:
  - Outputs: inst_resp, data_resp, mem_read, mem_write = 0; mem_address, mem_line_write, inst_rdata, data_rdata = 0.
  - Internal: state=IDLE, last_grant=INST (so the D-cache wins the first tie), buf_valid=0, pf_pending=0.
- Miss latency, request seen in IDLE at cycle 0:
  - mem_read/mem_write asserted from cycle 1.
  - resp is asserted in the same cycle as mem_resp.
  - The block is back in IDLE two cycles after mem_resp.
- Buffer hit latency: request seen in IDLE at cycle 0 gives inst_resp at cycle 1.
- Throughput: at most one transaction in flight.
- rst asserted in any state returns to IDLE on the next edge and discards any in-flight transaction. The adapter is reset by the same rst.
- An inst_read that arrives during PREF for pf_addr is served by HIT after PREF completes.

## Test plan
- Reset: hold rst 2 cycles → all outputs 0. Then apply inst_read to 0x0000_0040 → mem_read=1 with mem_address=0x0000_0040 at the next cycle.
- Tie: inst_read at 0x100 and data_read at 0x200 in the same cycle after reset → DATA served first, then INST. Repeat the tie → INST served first.
- Sequential prefetch: I-miss at 0x1000 completes, then PREF to 0x1020. inst_read at 0x1024 → inst_resp one cycle after the request, data equal to the line at 0x1020, and a PREF to 0x1040 follows.
- Coherence: buffer holds 0x1020; data_write to 0x1020 with 0xAA..AA completes. inst_read at 0x1020 → full memory read, inst_rdata=0xAA..AA.
- Wrap: I-miss at 0xFFFF_FFE0 → PREF issues mem_address 0x0000_0000.
- Reset mid-PREF: assert rst while mem_read=1 → next cycle mem_read=0, buf_valid=0, and the next inst_read misses.

Source files
------------

// File: rtl/mem_scheduler_if.sv
// Line-wide memory port bundle shared by the I-cache, D-cache and adapter.
// The scheduler uses the slave view; the cache/adapter side uses master.
interface mem_scheduler_if;
    logic [31:0]  inst_address;
    logic         inst_read;
    logic         inst_resp;
    logic [255:0] inst_rdata;
    logic [31:0]  data_address;
    logic         data_read;
    logic         data_write;
    logic [255:0] data_wdata;
    logic         data_resp;
    logic [255:0] data_rdata;
    logic [31:0]  mem_address;
    logic         mem_read;
    logic         mem_write;
    logic [255:0] mem_line_write;
    logic [255:0] mem_line_read;
    logic         mem_resp;

    modport slave (
        input  inst_address, inst_read,
        input  data_address, data_read, data_write, data_wdata,
        input  mem_line_read, mem_resp,
        output inst_resp, inst_rdata, data_resp, data_rdata,
        output mem_address, mem_read, mem_write, mem_line_write
    );

    modport master (
        output inst_address, inst_read,
        output data_address, data_read, data_write, data_wdata,
        output mem_line_read, mem_resp,
        input  inst_resp, inst_rdata, data_resp, data_rdata,
        input  mem_address, mem_read, mem_write, mem_line_write
    );
endinterface

// File: rtl/mem_scheduler.sv
// Round-robin I/D memory port scheduler with a one-line
// next-line instruction prefetch buffer.
module mem_scheduler #(
    parameter bit PREFETCH_EN = 1'b1
) (
    input logic           clk,
    input logic           rst,
    mem_scheduler_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE, INST, DATA, PREF, HIT, DONE
    } state_t;

    localparam logic GRANT_INST = 1'b0;
    localparam logic GRANT_DATA = 1'b1;

    state_t       state;
    logic         last_grant;
    logic         buf_valid;
    logic [26:0]  buf_tag;
    logic [255:0] buf_line;
    logic         pf_pending;
    logic [26:0]  pf_addr;

    logic [26:0] inst_tag;
    logic        data_req;
    logic        hit;
    logic        grant_i;
    logic        grant_d;
    logic        go_pref;

    assign inst_tag = bus.inst_address[31:5];
    assign data_req = bus.data_read | bus.data_write;
    assign hit = PREFETCH_EN && bus.inst_read && buf_valid
                 && (inst_tag == buf_tag);
    assign grant_d = !hit && data_req
                     && (!bus.inst_read || last_grant == GRANT_INST);
    assign grant_i = !hit && bus.inst_read
                     && (!data_req || last_grant == GRANT_DATA);
    assign go_pref = PREFETCH_EN && pf_pending
                     && !bus.inst_read && !data_req;

    // Responses line up with the adapter's completion pulse.
    assign bus.inst_resp = (state == HIT)
                           || (state == INST && bus.mem_resp);
    assign bus.data_resp = (state == DATA) && bus.mem_resp;
    assign bus.inst_rdata = (state == HIT) ? buf_line :
                            (state == INST && bus.mem_resp) ?
                            bus.mem_line_read : '0;
    assign bus.data_rdata = (state == DATA && bus.mem_resp) ?
                            bus.mem_line_read : '0;

    // Scheduler FSM, adapter request registers and prefetch buffer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state              <= IDLE;
            last_grant         <= GRANT_INST;
            buf_valid          <= 1'b0;
            buf_tag            <= '0;
            buf_line           <= '0;
            pf_pending         <= 1'b0;
            pf_addr            <= '0;
            bus.mem_address    <= '0;
            bus.mem_read       <= 1'b0;
            bus.mem_write      <= 1'b0;
            bus.mem_line_write <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    unique case (1'b1)
                        hit: state <= HIT;
                        grant_d: begin
                            state           <= DATA;
                            last_grant      <= GRANT_DATA;
                            bus.mem_address <= {bus.data_address[31:5], 5'b0};
                            bus.mem_read    <= bus.data_read;
                            bus.mem_write   <= bus.data_write;
                            if (bus.data_write)
                                bus.mem_line_write <= bus.data_wdata;
                        end
                        grant_i: begin
                            state           <= INST;
                            last_grant      <= GRANT_INST;
                            bus.mem_address <= {inst_tag, 5'b0};
                            bus.mem_read    <= 1'b1;
                        end
                        go_pref: begin
                            state           <= PREF;
                            bus.mem_address <= {pf_addr, 5'b0};
                            bus.mem_read    <= 1'b1;
                        end
                        default: state <= IDLE;
                    endcase
                end
                INST: begin
                    if (bus.mem_resp) begin
                        state        <= DONE;
                        bus.mem_read <= 1'b0;
                        if (PREFETCH_EN) begin
                            pf_addr    <= bus.mem_address[31:5] + 27'd1;
                            pf_pending <= 1'b1;
                            buf_valid  <= 1'b0;
                        end
                    end
                end
                DATA: begin
                    if (bus.mem_resp) begin
                        state         <= DONE;
                        bus.mem_read  <= 1'b0;
                        bus.mem_write <= 1'b0;
                        if (bus.mem_write
                            && bus.mem_address[31:5] == buf_tag)
                            buf_valid <= 1'b0;
                    end
                end
                PREF: begin
                    if (bus.mem_resp) begin
                        state        <= DONE;
                        bus.mem_read <= 1'b0;
                        buf_line     <= bus.mem_line_read;
                        buf_tag      <= pf_addr;
                        buf_valid    <= 1'b1;
                        pf_pending   <= 1'b0;
                    end
                end
                HIT: begin
                    state <= DONE;
                    if (PREFETCH_EN) begin
                        pf_addr    <= inst_tag + 27'd1;
                        pf_pending <= 1'b1;
                        buf_valid  <= 1'b0;
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_scheduler.sv
// Directed testbench for mem_scheduler: arbitration, prefetch,
// buffer hits, write coherence, address wrap and reset recovery.
module tb_mem_scheduler;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_scheduler_if bus ();

    mem_scheduler #(.PREFETCH_EN(1'b1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int vectors = 0;
    int miscompares = 0;

    localparam logic [255:0] LINE_AA = {32{8'hAA}};

    function automatic logic [255:0] line_of(input logic [31:0] a);
        return {8{a ^ 32'h5A5A_5A5A}};
    endfunction

    task automatic clear_inputs();
        bus.inst_address  = '0;
        bus.inst_read     = 1'b0;
        bus.data_address  = '0;
        bus.data_read     = 1'b0;
        bus.data_write    = 1'b0;
        bus.data_wdata    = '0;
        bus.mem_line_read = '0;
        bus.mem_resp      = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        clear_inputs();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Adapter model: waits for a request, optionally stalls, then
    // raises mem_resp at a negedge and returns 1 ns later.
    task automatic serve(input int lat, input logic [255:0] line,
                         output bit ok, output int cyc,
                         output logic [31:0] addr, output logic wr,
                         output logic [255:0] wline);
        ok = 1'b0;
        cyc = 0;
        addr = '0;
        wr = 1'b0;
        wline = '0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (bus.mem_read || bus.mem_write) begin
                ok = 1'b1;
                cyc = i;
                break;
            end
        end
        if (ok) begin
            repeat (lat) @(negedge clk);
            addr = bus.mem_address;
            wr = bus.mem_write;
            wline = bus.mem_line_write;
            bus.mem_line_read = line;
            bus.mem_resp = 1'b1;
            #1;
        end
    endtask

    task automatic end_resp(input bit clr_i, input bit clr_d);
        @(negedge clk);
        bus.mem_resp = 1'b0;
        bus.mem_line_read = '0;
        if (clr_i) bus.inst_read = 1'b0;
        if (clr_d) begin
            bus.data_read = 1'b0;
            bus.data_write = 1'b0;
        end
    endtask

    task automatic test_reset();
        bit ok; int cyc; logic [31:0] a; logic w; logic [255:0] wl;
        rst = 1'b1;
        clear_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        vectors++;
        if ({bus.inst_resp, bus.data_resp, bus.mem_read, bus.mem_write} !== 4'b0) begin
            miscompares++;
            $display("FAIL reset_flags: got %b want 0000",
                     {bus.inst_resp, bus.data_resp, bus.mem_read, bus.mem_write});
        end
        vectors++;
        if (bus.mem_address !== 32'h0 || bus.mem_line_write !== 256'h0) begin
            miscompares++;
            $display("FAIL reset_mem_bus: got addr %h line %h want 0",
                     bus.mem_address, bus.mem_line_write);
        end
        vectors++;
        if (bus.inst_rdata !== 256'h0 || bus.data_rdata !== 256'h0) begin
            miscompares++;
            $display("FAIL reset_rdata: got %h / %h want 0",
                     bus.inst_rdata, bus.data_rdata);
        end
        rst = 1'b0;
        bus.inst_read = 1'b1;
        bus.inst_address = 32'h0000_0040;
        serve(0, line_of(32'h40), ok, cyc, a, w, wl);
        vectors++;
        if (!ok || cyc != 1 || a !== 32'h40 || w !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_first_miss: got ok %0d cyc %0d addr %h wr %b want 1 1 00000040 0",
                     ok, cyc, a, w);
        end
        vectors++;
        if (bus.inst_resp !== 1'b1 || bus.inst_rdata !== line_of(32'h40)) begin
            miscompares++;
            $display("FAIL reset_first_resp: got resp %b data %h want 1 %h",
                     bus.inst_resp, bus.inst_rdata, line_of(32'h40));
        end
        end_resp(1'b1, 1'b0);
        serve(0, line_of(32'h60), ok, cyc, a, w, wl);
        vectors++;
        if (!ok || a !== 32'h60 || bus.inst_resp !== 1'b0 || bus.data_resp !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_pref: got ok %0d addr %h resp %b%b want 1 00000060 00",
                     ok, a, bus.inst_resp, bus.data_resp);
        end
        end_resp(1'b0, 1'b0);
    endtask

    task automatic test_tie();
        bit ok; int cyc; logic [31:0] a; logic w; logic [255:0] wl;
        do_reset();
        bus.inst_read = 1'b1;
        bus.inst_address = 32'h100;
        bus.data_read = 1'b1;
        bus.data_address = 32'h200;
        serve(0, line_of(32'h200), ok, cyc, a, w, wl);
        vectors++;
        if (!ok || a !== 32'h200 || {bus.inst_resp, bus.data_resp} !== 2'b01
            || bus.data_rdata !== line_of(32'h200)) begin
            miscompares++;
            $display("FAIL tie_first_data: got addr %h resp %b%b want 00000200 01",
                     a, bus.inst_resp, bus.data_resp);
        end
        end_resp(1'b0, 1'b1);
        bus.data_read = 1'b1;
        bus.data_address = 32'h300;
        serve(0, line_of(32'h100), ok, cyc, a, w, wl);
        vectors++;
        if (!ok || a !== 32'h100 || {bus.inst_resp, bus.data_resp} !== 2'b10
            || bus.inst_rdata !== line_of(32'h100)) begin
            miscompares++;
            $display("FAIL tie_second_inst: got addr %h resp %b%b want 00000100 10",
                     a, bus.inst_resp, bus.data_resp);
        end
        end_resp(1'b1, 1'b0);
        serve(0, line_of(32'h300), ok, cyc, a, w, wl);
        vectors++;
        if (!ok || a !== 32'h300 || bus.data_resp !== 1'b1) begin
            miscompares++;
            $display("FAIL tie_data_over_pref: got addr %h resp %b want 00000300 1",
                     a, bus.data_resp);
        end
        end_resp(1'b0, 1'b1);
        serve(0, line_of(32'h120), ok, cyc, a, w, wl);
        vectors++;
        if (!ok || a !== 32'h120) begin
            miscompares++;
            $display("FAIL tie_pref: got addr %h want 00000120", a);
        end
        end_resp(1'b0, 1'b0);
    endtask

    task automatic test_prefetch();
        bit ok; int cyc; logic [31:0] a; logic w; logic [255:0] wl;
        do_reset();
        bus.inst_read = 1'b1;
        bus.inst_address = 32'h1000;
        serve(1, line_of(32'h1000), ok, cyc, a, w, wl);
        vectors++;
        if (!ok || a !== 32'h1000 || bus.mem_read !== 1'b1 || bus.inst_resp !== 1'b1) begin
            miscompares++;
            $display("FAIL pf_miss: got addr %h rd %b resp %b want 00001000 1 1",
                     a, bus.mem_read, bus.inst_resp);
        end
        end_resp(1'b1, 1'b0);
        serve(0, line_of(32'h1020), ok, cyc, a, w, wl);
        vectors++;
        if (!ok || a !== 32'h1020) begin
            miscompares++;
            $display("FAIL pf_next_line: got addr %h want 00001020", a);
        end
        end_resp(1'b0, 1'b0);
        @(negedge clk);
        bus.inst_read = 1'b1;
        bus.inst_address = 32'h1024;
        @(negedge clk);
        vectors++;
        if (bus.inst_resp !== 1'b1 || bus.mem_read !== 1'b0
            || bus.inst_rdata !== line_of(32'h1020)) begin
            miscompares++;
            $display("FAIL pf_hit: got resp %b rd %b data %h want 1 0 %h",
                     bus.inst_resp, bus.mem_read, bus.inst_rdata, line_of(32'h1020));
        end
        end_resp(1'b1, 1'b0);
        serve(0, line_of(32'h1040), ok, cyc, a, w, wl);
        vectors++;
        if (!ok || a !== 32'h1040 || bus.inst_resp !== 1'b0) begin
            miscompares++;
            $display("FAIL pf_after_hit: got addr %h resp %b want 00001040 0",
                     a, bus.inst_resp);
        end
        end_resp(1'b0, 1'b0);
    endtask

    task automatic test_coherence();
        bit ok; int cyc; logic [31:0] a; logic w; logic [255:0] wl;
        do_reset();
        bus.inst_read = 1'b1;
        bus.inst_address = 32'h1000;
        serve(0, line_of(32'h1000), ok, cyc, a, w, wl);
        end_resp(1'b1, 1'b0);
        serve(0, line_of(32'h1020), ok, cyc, a, w, wl);
        end_resp(1'b0, 1'b0);
        bus.data_write = 1'b1;
        bus.data_address = 32'h1020;
        bus.data_wdata = LINE_AA;
        serve(0, '0, ok, cyc, a, w, wl);
        vectors++;
        if (!ok || a !== 32'h1020 || w !== 1'b1 || wl !== LINE_AA
            || bus.data_resp !== 1'b1) begin
            miscompares++;
            $display("FAIL coh_write: got addr %h wr %b line %h resp %b want 00001020 1 aa.. 1",
                     a, w, wl, bus.data_resp);
        end
        end_resp(1'b0, 1'b1);
        @(negedge clk);
        bus.inst_read = 1'b1;
        bus.inst_address = 32'h1020;
        serve(0, LINE_AA, ok, cyc, a, w, wl);
        vectors++;
        if (!ok || cyc != 1 || a !== 32'h1020 || w !== 1'b0) begin
            miscompares++;
            $display("FAIL coh_refetch: got ok %0d cyc %0d addr %h want 1 1 00001020",
                     ok, cyc, a);
        end
        vectors++;
        if (bus.inst_resp !== 1'b1 || bus.inst_rdata !== LINE_AA) begin
            miscompares++;
            $display("FAIL coh_data: got resp %b data %h want 1 %h",
                     bus.inst_resp, bus.inst_rdata, LINE_AA);
        end
        end_resp(1'b1, 1'b0);
        serve(0, line_of(32'h1040), ok, cyc, a, w, wl);
        end_resp(1'b0, 1'b0);
    endtask

    task automatic test_wrap();
        bit ok; int cyc; logic [31:0] a; logic w; logic [255:0] wl;
        do_reset();
        bus.inst_read = 1'b1;
        bus.inst_address = 32'hFFFF_FFE0;
        serve(0, line_of(32'hFFFF_FFE0), ok, cyc, a, w, wl);
        vectors++;
        if (!ok || a !== 32'hFFFF_FFE0) begin
            miscompares++;
            $display("FAIL wrap_miss: got addr %h want ffffffe0", a);
        end
        end_resp(1'b1, 1'b0);
        serve(0, line_of(32'h0), ok, cyc, a, w, wl);
        vectors++;
        if (!ok || a !== 32'h0 || w !== 1'b0) begin
            miscompares++;
            $display("FAIL wrap_pref: got ok %0d addr %h want 1 00000000", ok, a);
        end
        end_resp(1'b0, 1'b0);
    endtask

    task automatic test_done_hold();
        bit ok; int cyc; logic [31:0] a; logic w; logic [255:0] wl;
        bit extra;
        do_reset();
        bus.data_write = 1'b1;
        bus.data_address = 32'h0000_051F;
        bus.data_wdata = {8{32'hDEAD_BEEF}};
        serve(2, '0, ok, cyc, a, w, wl);
        vectors++;
        if (!ok || a !== 32'h500 || bus.mem_write !== 1'b1 || bus.mem_read !== 1'b0
            || wl !== {8{32'hDEAD_BEEF}} || bus.data_resp !== 1'b1) begin
            miscompares++;
            $display("FAIL hold_write: got addr %h wr %b rd %b resp %b want 00000500 1 0 1",
                     a, bus.mem_write, bus.mem_read, bus.data_resp);
        end
        @(negedge clk);
        bus.mem_resp = 1'b0;
        @(negedge clk);
        bus.data_write = 1'b0;
        extra = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (bus.mem_read || bus.mem_write) extra = 1'b1;
        end
        vectors++;
        if (extra !== 1'b0) begin
            miscompares++;
            $display("FAIL hold_no_replay: got second request %b want 0", extra);
        end
    endtask

    task automatic test_reset_mid_pref();
        bit ok; int cyc; logic [31:0] a; logic w; logic [255:0] wl;
        bit extra;
        do_reset();
        bus.inst_read = 1'b1;
        bus.inst_address = 32'h2000;
        serve(0, line_of(32'h2000), ok, cyc, a, w, wl);
        end_resp(1'b1, 1'b0);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.mem_read) begin
                ok = 1'b1;
                break;
            end
        end
        vectors++;
        if (!ok || bus.mem_address !== 32'h2020) begin
            miscompares++;
            $display("FAIL midpref_start: got ok %0d addr %h want 1 00002020",
                     ok, bus.mem_address);
        end
        rst = 1'b1;
        @(negedge clk);
        vectors++;
        if (bus.mem_read !== 1'b0) begin
            miscompares++;
            $display("FAIL midpref_abort: got mem_read %b want 0", bus.mem_read);
        end
        rst = 1'b0;
        extra = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (bus.mem_read) extra = 1'b1;
        end
        vectors++;
        if (extra !== 1'b0) begin
            miscompares++;
            $display("FAIL midpref_no_restart: got mem_read %b want 0", extra);
        end
        bus.inst_read = 1'b1;
        bus.inst_address = 32'h2020;
        serve(0, line_of(32'h2020), ok, cyc, a, w, wl);
        vectors++;
        if (!ok || cyc != 1 || a !== 32'h2020 || bus.inst_rdata !== line_of(32'h2020)) begin
            miscompares++;
            $display("FAIL midpref_miss: got ok %0d cyc %0d addr %h want 1 1 00002020",
                     ok, cyc, a);
        end
        end_resp(1'b1, 1'b0);
        serve(0, line_of(32'h2040), ok, cyc, a, w, wl);
        end_resp(1'b0, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        test_reset();
        test_tie();
        test_prefetch();
        test_coherence();
        test_wrap();
        test_done_hold();
        test_reset_mid_pref();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
